// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - shared sizes and pointer helper for the sync_fifo read drainer
package fifo_rd_stream_pkg;

  localparam int W_DEFAULT = 8;
  localparam int SKID      = 3;
  localparam int LEVEL_W   = 2;
  localparam logic [LEVEL_W-1:0] PTR_LAST = 2'd2;

  // Mod-3 increment shared by both skid pointers.
  function automatic logic [LEVEL_W-1:0] ptr_inc(input logic [LEVEL_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf.sv
// rtl/fifo_rd_stream_skid_buf.sv - 3-entry circular register buffer behind the FIFO read port
module rd_skid_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout,
  output logic [LEVEL_W-1:0] occ
);

  logic [W-1:0]       mem [SKID];
  logic [LEVEL_W-1:0] rd_ptr;
  logic [LEVEL_W-1:0] wr_ptr;

  // The caller reserves a slot before pushing and only pops when occ != 0,
  // so no full/empty guarding is needed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID; i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      occ <= occ + LEVEL_W'(push) - LEVEL_W'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains sync_fifo into a valid/ready stream at one word per clock
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_emp,
  input  logic [W-1:0]       fifo_d,
  output logic               fifo_rd,
  output logic [W-1:0]       m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [LEVEL_W-1:0] level
);

  logic               inflight;
  logic               pop;
  logic [LEVEL_W-1:0] occ;

  // A read is only issued when a skid slot is guaranteed for its data, counting
  // the word still in flight; m_ready is deliberately left out of this path.
  assign fifo_rd = !rst && !fifo_emp && ((3'(occ) + 3'(inflight)) < 3'(SKID));

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd;
    end
  end

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign level   = occ;

  rd_skid_buf #(
    .W (W)
  ) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (fifo_d),
    .pop  (pop),
    .dout (m_data),
    .occ  (occ)
  );

endmodule
